// File: rtl/gapbuf_reader.sv
// Gap-buffer reader: issues one-cycle get pulses, forwards request info downstream,
// enforces a programmable idle gap between gets and tracks protocol errors.
module gapbuf_reader #(
    parameter int INFO = 32,
    parameter int GAPW = 4,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ien,
    input  logic [GAPW-1:0] igap,
    input  logic            flush,
    input  logic            ireq,
    input  logic [INFO-1:0] ireqinfo,
    output logic            oget,
    input  logic            ordy,
    output logic            ovld,
    output logic [INFO-1:0] odat,
    output logic [CNTW-1:0] ocnt,
    output logic            oerr
);

    typedef enum logic [1:0] {
        IDLE,
        GET,
        GAP
    } state_t;

    state_t          state;
    logic [GAPW-1:0] gap_cnt;

    // Combinational so flush and reset can kill the pulse in the same cycle.
    assign oget = (state == GET) & ~flush & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            ovld    <= 1'b0;
            odat    <= '0;
            ocnt    <= '0;
            oerr    <= 1'b0;
        end else begin
            ovld <= 1'b0;
            if (flush) begin
                state   <= IDLE;
                gap_cnt <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (ien && ireq && ordy)
                            state <= GET;
                    end
                    GET: begin
                        odat    <= ireqinfo;
                        gap_cnt <= igap;
                        ovld    <= 1'b1;
                        ocnt    <= ocnt + CNTW'(1);
                        if (!ireq)
                            oerr <= 1'b1;
                        state <= (igap != '0) ? GAP : IDLE;
                    end
                    GAP: begin
                        gap_cnt <= gap_cnt - GAPW'(1);
                        if (gap_cnt <= GAPW'(1))
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gapbuf_reader.sv
// Directed bench for gapbuf_reader with a scoreboard of expected deliveries.
// A narrow counter keeps the wrap-around test short.
module tb_gapbuf_reader;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          ien;
    logic [3:0]    igap;
    logic          flush;
    logic          ireq;
    logic [31:0]   ireqinfo;
    logic          oget;
    logic          ordy;
    logic          ovld;
    logic [31:0]   odat;
    logic [CW-1:0] ocnt;
    logic          oerr;

    always #5 clk = ~clk;

    gapbuf_reader #(
        .INFO(32),
        .GAPW(4),
        .CNTW(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ien(ien),
        .igap(igap),
        .flush(flush),
        .ireq(ireq),
        .ireqinfo(ireqinfo),
        .oget(oget),
        .ordy(ordy),
        .ovld(ovld),
        .odat(odat),
        .ocnt(ocnt),
        .oerr(oerr)
    );

    typedef struct {
        logic [31:0]   d;
        logic [CW-1:0] c;
    } exp_t;

    exp_t          sb[$];
    logic [CW-1:0] cnt_m;
    logic          err_m;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are sampled 1ns after the edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (ovld) begin
            if (sb.size() == 0) begin
                chk("spurious_ovld", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("odat", odat, e.d);
                chk("ocnt", ocnt, e.c);
            end
        end
        chk("oerr", oerr, err_m);
    endtask

    task automatic wait_oget(output int t);
        bit seen;
        seen = 0;
        t = -1;
        for (int i = 0; i < 64; i++) begin
            if (!seen) begin
                step();
                if (oget) begin
                    seen = 1;
                    t = cyc;
                end
            end
        end
        if (!seen)
            chk("oget_timeout", 0, 1);
    endtask

    // One transfer; drop=1 lowers ireq during the GET cycle.
    task automatic xfer(input logic [31:0] info, input logic [3:0] gap,
                        input bit drop, output int t);
        ireqinfo = info;
        igap     = gap;
        ireq     = 1'b1;
        wait_oget(t);
        if (t < 0) begin
            ireq = 1'b0;
            return;
        end
        if (drop) begin
            ireq  = 1'b0;
            err_m = 1'b1;
        end
        cnt_m++;
        sb.push_back('{info, cnt_m});
        step();
        ireq = 1'b0;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        err_m = 1'b0;
        cnt_m = '0;
        sb.delete();
        step();
        step();
        chk("rst_oget", oget, 0);
        chk("rst_ovld", ovld, 0);
        chk("rst_odat", odat, 0);
        chk("rst_ocnt", ocnt, 0);
        chk("rst_oerr", oerr, 0);
        rst = 1'b0;
    endtask

    initial begin
        int t, t1, t2, c0, n;
        rst      = 1'b1;
        ien      = 1'b1;
        ordy     = 1'b1;
        igap     = '0;
        flush    = 1'b0;
        ireq     = 1'b0;
        ireqinfo = '0;
        cnt_m    = '0;
        err_m    = 1'b0;

        do_reset();
        cyc = 0;
        while (cyc < 10)
            step();
        xfer(32'hA5A5A5A5, 4'd0, 0, t);
        chk("lat_oget_cycle", t, 11);
        chk("lat_ovld_cycle", cyc, 12);
        chk("lat_ovld", ovld, 1);
        chk("first_ocnt", ocnt, 1);

        xfer(32'h11, 4'd3, 0, t1);
        xfer(32'h22, 4'd3, 0, t2);
        chk("gap3_spacing", t2 - t1, 5);
        xfer(32'h33, 4'd0, 0, t1);
        chk("gap3_spacing2", t1 - t2, 5);
        xfer(32'h44, 4'd0, 0, t2);
        chk("gap0_spacing", t2 - t1, 2);
        xfer(32'h55, 4'd15, 0, t1);
        xfer(32'h66, 4'd0, 0, t2);
        chk("gap15_spacing", t2 - t1, 17);

        // flush during GET
        ireqinfo = 32'h77;
        ireq     = 1'b1;
        wait_oget(t);
        flush = 1'b1;
        #1;
        chk("flush_get_oget", oget, 0);
        step();
        flush = 1'b0;
        ireq  = 1'b0;
        chk("flush_get_ovld", ovld, 0);
        chk("flush_get_ocnt", ocnt, cnt_m);
        chk("flush_get_odat", odat, 32'h66);
        c0 = cyc;
        xfer(32'h88, 4'd2, 0, t);
        chk("flush_get_idle", t - c0, 1);

        // flush during a long gap
        xfer(32'h99, 4'd15, 0, t);
        flush = 1'b1;
        step();
        flush = 1'b0;
        c0 = cyc;
        xfer(32'hAA, 4'd0, 0, t);
        chk("flush_gap_idle", t - c0, 1);

        // flush coinciding with the GET entry condition
        ireq  = 1'b1;
        flush = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            n += int'(oget);
        end
        chk("flush_entry_block", n, 0);
        flush = 1'b0;
        c0 = cyc;
        xfer(32'hAB, 4'd3, 0, t1);
        chk("flush_entry_release", t1 - c0, 1);

        // ordy/ien falling mid-transfer does not abort it
        ireqinfo = 32'hBB;
        igap     = 4'd3;
        ireq     = 1'b1;
        wait_oget(t1);
        ordy = 1'b0;
        ien  = 1'b0;
        cnt_m++;
        sb.push_back('{32'hBB, cnt_m});
        step();
        chk("ordy_low_ovld", ovld, 1);
        ireq = 1'b0;
        ordy = 1'b1;
        ien  = 1'b1;
        xfer(32'hBC, 4'd0, 0, t2);
        chk("ordy_low_gap", t2 - t1, 5);

        // ordy held low blocks the get
        ordy     = 1'b0;
        ireqinfo = 32'hCC;
        ireq     = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            n += int'(oget);
        end
        chk("ordy_block", n, 0);
        ordy = 1'b1;
        c0 = cyc;
        xfer(32'hCC, 4'd0, 0, t);
        chk("ordy_release", t - c0, 1);

        // protocol error is sticky across traffic and flush
        xfer(32'hDD, 4'd0, 1, t);
        chk("err_set", oerr, 1);
        chk("err_odat", odat, 32'hDD);
        xfer(32'hEE, 4'd1, 0, t);
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        chk("err_sticky", oerr, 1);

        // reset in the middle of GET
        ireqinfo = 32'hFF;
        ireq     = 1'b1;
        wait_oget(t);
        rst = 1'b1;
        #1;
        chk("rst_get_oget", oget, 0);
        ireq = 1'b0;
        do_reset();

        // counter wrap
        for (int i = 0; i < (1 << CW) - 1; i++)
            xfer(32'(i) ^ 32'h5A000000, 4'd0, 0, t);
        chk("cnt_full", ocnt, {CW{1'b1}});
        xfer(32'h12345678, 4'd0, 0, t);
        chk("cnt_wrap", ocnt, 0);
        step();
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gapbuf_reader.md
GAPBUF_READER -- requirements
Module: gapbuf_reader

Interface
REQ-001 Parameter INFO, default 32: request info width; SHALL match the paired gap buffer.
REQ-002 Parameter GAPW, default 4: width of the programmable inter-get gap.
REQ-003 Parameter CNTW, default 16: width of the delivered-word counter.
REQ-004 clk  input  1: the single clock; all logic SHALL be on its rising edge.
REQ-005 rst  input  1: reset, synchronous and active-high.
REQ-006 ien  input  1: enable; when low, no new get SHALL be started.
REQ-007 igap  input  GAPW: minimum idle cycles after each get, sampled when the get is issued.
REQ-008 flush  input  1: synchronous abort of the current transfer.
REQ-009 ireq  input  1: request pending from the gap buffer; low for at least one cycle after each get.
REQ-010 ireqinfo  input  INFO: request info, valid while ireq is high.
REQ-011 oget  output  1: one-cycle get pulse to the gap buffer.
REQ-012 ordy  input  1: downstream can accept a word.
REQ-013 ovld  output  1: one-cycle strobe that odat is new.
REQ-014 odat  output  INFO: delivered request info.
REQ-015 ocnt  output  CNTW: count of delivered words.
REQ-016 oerr  output  1: sticky protocol error flag.

Function
REQ-017 The FSM SHALL have three states: IDLE, GET and GAP.
REQ-018 IDLE -> GET when ien & ireq & ordy & !flush; otherwise it SHALL stay in IDLE.
REQ-019 oget SHALL equal (state==GET) & !flush, so it is high for exactly one cycle per transfer.
REQ-020 In GET, when flush is low, odat SHALL load ireqinfo, igap SHALL be latched into the gap counter, and ovld SHALL be 1 on the next cycle.
REQ-021 Latency: ireq sampled high in IDLE at cycle t -> oget at t+1 -> ovld/odat at t+2.
REQ-022 GET -> GAP when the latched gap is nonzero; GET -> IDLE when it is zero.
REQ-023 GAP SHALL decrement the counter each cycle and go to IDLE when the counter reaches 1.
REQ-024 The gap from the first oget to the next oget SHALL be at least igap+2 cycles.
REQ-025 ovld SHALL be 0 in every cycle except the one after a non-flushed GET.
REQ-026 odat SHALL hold its value between loads.
REQ-027 ocnt SHALL increment by 1 on each ovld.
REQ-028 ocnt SHALL wrap modulo 2^CNTW, from all-ones to 0.
REQ-029 If ireq is low in GET while flush is low, oerr SHALL be set and stay set until rst; the transfer SHALL still complete.
REQ-030 flush in any state SHALL put the FSM in IDLE on the next edge, clear the gap counter, and suppress that cycle's oget and the following ovld.
REQ-031 flush SHALL leave odat, ocnt and oerr unchanged.
REQ-032 ordy or ien going low in GET or GAP SHALL NOT abort the transfer; it only blocks the next IDLE -> GET.
REQ-033 flush together with a GET-entry condition: flush SHALL win and the FSM SHALL stay in IDLE.

Reset
REQ-034 While rst is high: state=IDLE, oget=0, ovld=0, odat=0, ocnt=0, oerr=0, gap counter=0.
REQ-035 rst SHALL take priority over flush and over every FSM transition.
REQ-036 rst asserted mid-GET SHALL force oget low in that cycle.

Verification
REQ-037 ien=1, ordy=1, igap=0, ireq high with info 0xA5A5A5A5 at cycle 10, dropping one cycle after oget -> oget at 11, ovld with odat=0xA5A5A5A5 at 12, ocnt=1.
REQ-038 igap=3 with ireq re-raised as early as the protocol allows -> oget pulses exactly 5 cycles apart.
REQ-039 flush asserted in the GET cycle -> oget=0, no ovld, FSM in IDLE, ocnt unchanged.
REQ-040 ireq forced low during GET -> oerr=1 and stays 1 through later traffic until rst.
REQ-041 ocnt preloaded by 65535 transfers, then one more -> ocnt=0.
REQ-042 ordy=0 with ireq high for 20 cycles, then ordy=1 -> no oget while ordy=0, first oget on the cycle after ordy is sampled high.
